// File: rtl/ex_muldiv.sv
// EX-stage multiply/divide unit owning the architectural HI/LO registers.
// Divide support (div/divu) is built only when MULDIV_DIVIDE_EN is defined.
module ex_muldiv (
    input  logic        clk,
    input  logic        reset,
    input  logic        Start,
    input  logic [2:0]  MDOp,
    input  logic [31:0] SrcA,
    input  logic [31:0] SrcB,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    state_t      state, state_next;
    logic [3:0]  count, count_next;
    logic [31:0] res_hi, res_lo;
    logic        res_ok;
    logic [31:0] hi_next, lo_next;
    logic        latch;
    logic [31:0] calc_hi, calc_lo;
    logic        calc_ok;

    // Sign-extend to 64 bits so one unsigned multiplier serves both mult and multu.
    logic        mul_signed;
    logic [63:0] mul_a, mul_b, product;

    assign mul_signed = (MDOp == 3'd1);
    assign mul_a      = {{32{mul_signed & SrcA[31]}}, SrcA};
    assign mul_b      = {{32{mul_signed & SrcB[31]}}, SrcB};
    assign product    = mul_a * mul_b;

    logic        div_op;
    logic [31:0] quo, rem;

`ifdef MULDIV_DIVIDE_EN
    // Divide magnitudes and fix signs afterwards; this also yields
    // 0x80000000 / -1 = 0x80000000 without overflow special-casing.
    logic        div_signed, neg_a, neg_b;
    logic [31:0] mag_a, mag_b, div_b, uq, ur;

    assign div_op     = (MDOp == 3'd3) || (MDOp == 3'd4);
    assign div_signed = (MDOp == 3'd3);
    assign neg_a      = div_signed & SrcA[31];
    assign neg_b      = div_signed & SrcB[31];
    assign mag_a      = neg_a ? (32'd0 - SrcA) : SrcA;
    assign mag_b      = neg_b ? (32'd0 - SrcB) : SrcB;
    assign div_b      = (mag_b == 32'd0) ? 32'd1 : mag_b;
    assign uq         = mag_a / div_b;
    assign ur         = mag_a % div_b;
    assign quo        = (neg_a ^ neg_b) ? (32'd0 - uq) : uq;
    assign rem        = neg_a ? (32'd0 - ur) : ur;
`else
    assign div_op = 1'b0;
    assign quo    = 32'd0;
    assign rem    = 32'd0;
`endif

    always_comb begin
        calc_hi = product[63:32];
        calc_lo = product[31:0];
        calc_ok = 1'b1;
        if (div_op) begin
            calc_hi = rem;
            calc_lo = quo;
            calc_ok = (SrcB != 32'd0);
        end
    end

    always_comb begin
        state_next = state;
        count_next = count;
        hi_next    = HI;
        lo_next    = LO;
        latch      = 1'b0;
        case (state)
            IDLE: begin
                if (Start) begin
                    case (MDOp)
                        3'd1, 3'd2: begin
                            latch      = 1'b1;
                            count_next = 4'd5;
                            state_next = BUSY;
                        end
                        3'd3, 3'd4: begin
                            if (div_op) begin
                                latch      = 1'b1;
                                count_next = 4'd10;
                                state_next = BUSY;
                            end
                        end
                        3'd5: hi_next = SrcA;
                        3'd6: lo_next = SrcA;
                        default: ;
                    endcase
                end
            end
            BUSY: begin
                // Start is deliberately ignored here; the result lands on the 1->0 step.
                count_next = count - 4'd1;
                if (count == 4'd1) begin
                    state_next = IDLE;
                    if (res_ok) begin
                        hi_next = res_hi;
                        lo_next = res_lo;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            count  <= 4'd0;
            HI     <= 32'd0;
            LO     <= 32'd0;
            res_hi <= 32'd0;
            res_lo <= 32'd0;
            res_ok <= 1'b0;
        end else begin
            state <= state_next;
            count <= count_next;
            HI    <= hi_next;
            LO    <= lo_next;
            if (latch) begin
                res_hi <= calc_hi;
                res_lo <= calc_lo;
                res_ok <= calc_ok;
            end
        end
    end

    assign Busy = (state == BUSY);

endmodule

// File: tb/tb_ex_muldiv.sv
// Self-checking bench for ex_muldiv: directed cases plus random ops against an
// arithmetic reference model; expectations follow MULDIV_DIVIDE_EN when defined.
module tb_ex_muldiv;

`ifdef MULDIV_DIVIDE_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        Start;
    logic [2:0]  MDOp;
    logic [31:0] SrcA, SrcB;
    logic        Busy;
    logic [31:0] HI, LO;

    int checks = 0;
    int errors = 0;
    logic [63:0] exp_q[$];
    logic [31:0] m_hi, m_lo;

    ex_muldiv dut (
        .clk   (clk),
        .reset (reset),
        .Start (Start),
        .MDOp  (MDOp),
        .SrcA  (SrcA),
        .SrcB  (SrcB),
        .Busy  (Busy),
        .HI    (HI),
        .LO    (LO)
    );

    // clock
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference model: new {HI,LO} and busy length for an op issued from IDLE.
    function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b, output int n);
        longint          sa, sb, q, r;
        longint unsigned p;
        logic [63:0]     res;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        n   = 0;
        res = {m_hi, m_lo};
        case (op)
            3'd1: begin p = sa * sb; res = p; n = 5; end
            3'd2: begin p = {32'd0, a} * {32'd0, b}; res = p; n = 5; end
            3'd3: if (DIV_EN) begin
                n = 10;
                if (b != 0) begin q = sa / sb; r = sa % sb; res = {r[31:0], q[31:0]}; end
            end
            3'd4: if (DIV_EN) begin
                n = 10;
                if (b != 0) begin res = {a % b, a / b}; end
            end
            3'd5: res = {a, m_lo};
            3'd6: res = {m_hi, a};
            default: ;
        endcase
        return res;
    endfunction

    // driver: issue one op, optionally poke Start during BUSY, check every cycle.
    task automatic do_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input bit inject, input logic [2:0] inj_op);
        int          n;
        logic [63:0] nxt, exp;
        logic [31:0] old_hi, old_lo;
        old_hi = m_hi;
        old_lo = m_lo;
        nxt    = model(op, a, b, n);
        exp_q.push_back(nxt);
        @(negedge clk);
        Start = 1'b1; MDOp = op; SrcA = a; SrcB = b;
        @(negedge clk);
        Start = 1'b0; MDOp = 3'd0; SrcA = $urandom; SrcB = $urandom;
        for (int i = 0; i < n; i++) begin
            check({tag, " busy"}, {31'd0, Busy}, 32'd1);
            check({tag, " hi_hold"}, HI, old_hi);
            check({tag, " lo_hold"}, LO, old_lo);
            if (inject && i == 1) begin
                Start = 1'b1; MDOp = inj_op; SrcA = $urandom; SrcB = $urandom;
            end else begin
                Start = 1'b0; MDOp = 3'd0;
            end
            @(negedge clk);
        end
        Start = 1'b0; MDOp = 3'd0;
        exp = exp_q.pop_front();
        check({tag, " busy_done"}, {31'd0, Busy}, 32'd0);
        check({tag, " hi"}, HI, exp[63:32]);
        check({tag, " lo"}, LO, exp[31:0]);
        m_hi = exp[63:32];
        m_lo = exp[31:0];
    endtask

    initial begin
        logic [2:0]  op;
        logic [31:0] a, b;

        // reset with a live Start request that must be ignored
        reset = 1'b1; Start = 1'b1; MDOp = 3'd5; SrcA = 32'hFFFF_0000; SrcB = 32'd0;
        m_hi = 32'd0; m_lo = 32'd0;
        repeat (2) @(negedge clk);
        reset = 1'b0; Start = 1'b0; MDOp = 3'd0;
        check("reset busy", {31'd0, Busy}, 32'd0);
        check("reset hi", HI, 32'd0);
        check("reset lo", LO, 32'd0);

        // directed cases
        do_op("mult", 3'd1, 32'hFFFF_FFFF, 32'd2, 1'b0, 3'd0);
        check("mult hi const", HI, 32'hFFFF_FFFF);
        check("mult lo const", LO, 32'hFFFF_FFFE);
        do_op("multu", 3'd2, 32'hFFFF_FFFF, 32'd2, 1'b0, 3'd0);
        check("multu hi const", HI, 32'h0000_0001);
        check("multu lo const", LO, 32'hFFFF_FFFE);
        do_op("div", 3'd3, 32'hFFFF_FFF9, 32'd2, 1'b0, 3'd0);
        do_op("divu", 3'd4, 32'd7, 32'd2, 1'b0, 3'd0);
        do_op("mthi11", 3'd5, 32'h11, 32'd0, 1'b0, 3'd0);
        do_op("mtlo22", 3'd6, 32'h22, 32'd0, 1'b0, 3'd0);
        do_op("div0", 3'd3, 32'd1234, 32'd0, 1'b0, 3'd0);
        check("div0 hi const", HI, 32'h11);
        check("div0 lo const", LO, 32'h22);
        do_op("divu0", 3'd4, 32'd99, 32'd0, 1'b0, 3'd0);
        do_op("div_ovf", 3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 3'd0);
        do_op("mthi", 3'd5, 32'hDEAD_BEEF, 32'd0, 1'b0, 3'd0);
        check("mthi hi const", HI, 32'hDEAD_BEEF);
        do_op("mult_inj", 3'd1, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1, 3'd6);
        do_op("mult_inj5", 3'd2, 32'hCAFE_F00D, 32'h0000_0003, 1'b1, 3'd5);
        do_op("none", 3'd0, 32'h5555_5555, 32'd1, 1'b0, 3'd0);
        do_op("reserved", 3'd7, 32'h6666_6666, 32'd1, 1'b0, 3'd0);

        // random ops, including divides by zero and Start pokes during BUSY
        for (int k = 0; k < 60; k++) begin
            op = 3'($urandom_range(0, 7));
            a  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
            b  = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 2) == 0) b = 32'($urandom_range(1, 9)) | {32{b[31]}};
            do_op("rand", op, a, b, ($urandom_range(0, 2) == 0), 3'($urandom_range(0, 7)));
        end

        // reset in the third busy cycle of a div: aborted, nothing lands later
        do_op("pre_mthi", 3'd5, 32'hA5A5_A5A5, 32'd0, 1'b0, 3'd0);
        @(negedge clk);
        Start = 1'b1; MDOp = 3'd3; SrcA = 32'd100; SrcB = 32'd7;
        @(negedge clk);
        Start = 1'b0; MDOp = 3'd0;
        for (int i = 0; i < 2; i++) begin
            check("abort busy", {31'd0, Busy}, {31'd0, DIV_EN});
            @(negedge clk);
        end
        check("abort busy3", {31'd0, Busy}, {31'd0, DIV_EN});
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort busy_rst", {31'd0, Busy}, 32'd0);
        check("abort hi_rst", HI, 32'd0);
        check("abort lo_rst", LO, 32'd0);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check("abort busy_after", {31'd0, Busy}, 32'd0);
            check("abort hi_after", HI, 32'd0);
            check("abort lo_after", LO, 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
